// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory-side signals of mem_arbiter.
// slave = arbiter view, master = requester/memory (environment) view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    // fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;
    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               mem_rdata, mem_done, mem_stall, mem_err,
        output i_ack, i_done, i_rdata, i_err,
               d_ack, d_done, d_rdata, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               mem_rdata, mem_done, mem_stall, mem_err,
        input  i_ack, i_done, i_rdata, i_err,
               d_ack, d_done, d_rdata, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between fetch and data requests.
// MEM_ARB_FAIRNESS_EN defined: ties go to the port not granted last.
// MEM_ARB_FAIRNESS_EN undefined: ties always go to the data port.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_fetch_req,
    input  logic       i_data_req,
`ifdef MEM_ARB_FAIRNESS_EN
    input  logic       i_last_owner,
`endif
    output logic [1:0] o_grant,     // [0] fetch, [1] data
    output logic       o_win_port,
    output logic       o_valid
);

    logic w_win;

    // Pick the winning port; a lone request always wins.
    always_comb begin
        w_win = PORT_D;
        if (i_fetch_req && i_data_req) begin
`ifdef MEM_ARB_FAIRNESS_EN
            w_win = (i_last_owner == PORT_D) ? PORT_I : PORT_D;
`else
            w_win = PORT_D;
`endif
        end else if (i_data_req) begin
            w_win = PORT_D;
        end else if (i_fetch_req) begin
            w_win = PORT_I;
        end
    end

    assign o_valid    = i_fetch_req | i_data_req;
    assign o_win_port = w_win;
    assign o_grant    = {o_valid && (w_win == PORT_D), o_valid && (w_win == PORT_I)};

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one stalling 16-bit memory between fetch (read-only)
// and data (read/write) ports, one transaction at a time.
// Optional feature macro: MEM_ARB_FAIRNESS_EN (round-robin tie breaking).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_err;
    logic              r_d_err;

    logic [1:0]        w_grant;
    logic              w_win;
    logic              w_valid;
    logic              w_idle;
    logic              w_busy;
    logic              w_accept;
    logic              w_complete;

`ifdef MEM_ARB_FAIRNESS_EN
    logic              r_last_owner;
`endif

    mem_arb_pick u_pick (
        .i_fetch_req  (bus.i_req),
        .i_data_req   (bus.d_req),
`ifdef MEM_ARB_FAIRNESS_EN
        .i_last_owner (r_last_owner),
`endif
        .o_grant      (w_grant),
        .o_win_port   (w_win),
        .o_valid      (w_valid)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_busy     = (r_state == BUSY);
    assign w_accept   = w_idle && w_valid;
    assign w_complete = w_busy && bus.mem_done;

    // Next-state logic: IDLE -> BUSY on accept, BUSY holds through stall until done, RESP -> IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = BUSY;
            BUSY: begin
                if (bus.mem_done)       w_next = RESP;
                else if (bus.mem_stall) w_next = BUSY;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, request latch and per-port result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= PORT_D;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_err   <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_win;
                r_we    <= (w_win == PORT_D) ? bus.d_we : 1'b0;
                r_addr  <= (w_win == PORT_D) ? bus.d_addr : bus.i_addr;
                r_wdata <= (w_win == PORT_D) ? bus.d_wdata : '0;
            end
            if (w_complete) begin
                if (r_owner == PORT_D) begin
                    r_d_rdata <= bus.mem_rdata;
                    r_d_err   <= bus.mem_err;
                end else begin
                    r_i_rdata <= bus.mem_rdata;
                    r_i_err   <= bus.mem_err;
                end
            end
        end
    end

`ifdef MEM_ARB_FAIRNESS_EN
    // Remember the last granted port for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= PORT_D;
        end else if (w_accept) begin
            r_last_owner <= w_win;
        end
    end
`endif

    assign bus.i_ack     = w_idle && w_grant[0];
    assign bus.d_ack     = w_idle && w_grant[1];
    assign bus.i_done    = (r_state == RESP) && (r_owner == PORT_I);
    assign bus.d_done    = (r_state == RESP) && (r_owner == PORT_D);
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_err     = r_i_err;
    assign bus.d_err     = r_d_err;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_rd    = w_busy && !r_we;
    assign bus.mem_wr    = w_busy && r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// stalling word memory model (configurable stall count, err on odd address).
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   stall_n;
    int   cnt;
    logic [15:0] mem [0:255];
    logic w_act;

    mem_arbiter_if bus ();

    mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: done after stall_n stall cycles, err on odd address, no write on err.
    assign w_act         = bus.mem_rd | bus.mem_wr;
    assign bus.mem_done  = w_act && (cnt == stall_n);
    assign bus.mem_stall = w_act && (cnt < stall_n);
    assign bus.mem_err   = bus.mem_done && bus.mem_addr[0];
    assign bus.mem_rdata = (bus.mem_done && bus.mem_rd && !bus.mem_err) ? mem[bus.mem_addr[8:1]] : 16'h0000;

    always @(posedge clk) begin
        if (w_act) begin
            if (bus.mem_done) begin
                cnt <= 0;
                if (bus.mem_wr && !bus.mem_err) mem[bus.mem_addr[8:1]] <= bus.mem_wdata;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read/write strobes must never overlap.
    always @(negedge clk) begin
        if (!rst && n_checks > 0) check("rd_wr_excl", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_i_ack"},  {31'd0, bus.i_ack},  0);
        check({pfx, "_d_ack"},  {31'd0, bus.d_ack},  0);
        check({pfx, "_i_done"}, {31'd0, bus.i_done}, 0);
        check({pfx, "_d_done"}, {31'd0, bus.d_done}, 0);
        check({pfx, "_i_err"},  {31'd0, bus.i_err},  0);
        check({pfx, "_d_err"},  {31'd0, bus.d_err},  0);
        check({pfx, "_mem_rd"}, {31'd0, bus.mem_rd}, 0);
        check({pfx, "_mem_wr"}, {31'd0, bus.mem_wr}, 0);
        check({pfx, "_i_rdata"},   {16'd0, bus.i_rdata},   0);
        check({pfx, "_d_rdata"},   {16'd0, bus.d_rdata},   0);
        check({pfx, "_mem_addr"},  {16'd0, bus.mem_addr},  0);
        check({pfx, "_mem_wdata"}, {16'd0, bus.mem_wdata}, 0);
    endtask

    // Called just after a rising edge while the DUT is IDLE; returns the same way.
    task automatic run_op(input logic port_d, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int stall,
                          input logic [15:0] exp_rdata, input logic exp_err);
        stall_n = stall;
        if (port_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        @(negedge clk);
        check("ack",       {31'd0, port_d ? bus.d_ack : bus.i_ack}, 1);
        check("other_ack", {31'd0, port_d ? bus.i_ack : bus.d_ack}, 0);
        check("strobe_t0", {31'd0, bus.mem_rd | bus.mem_wr}, 0);
        @(posedge clk); #1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        bus.d_addr = 16'hFFFF; bus.i_addr = 16'hFFFF; bus.d_wdata = 16'hFFFF; bus.d_we = 1'b0;
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            check("busy_rd",   {31'd0, bus.mem_rd}, {31'd0, ~we});
            check("busy_wr",   {31'd0, bus.mem_wr}, {31'd0, we});
            check("busy_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
            if (we) check("busy_wdata", {16'd0, bus.mem_wdata}, {16'd0, wdata});
            check("busy_done", {31'd0, bus.i_done | bus.d_done}, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("done",       {31'd0, port_d ? bus.d_done : bus.i_done}, 1);
        check("other_done", {31'd0, port_d ? bus.i_done : bus.d_done}, 0);
        check("resp_strobe", {31'd0, bus.mem_rd | bus.mem_wr}, 0);
        if (!we) check("rdata", {16'd0, port_d ? bus.d_rdata : bus.i_rdata}, {16'd0, exp_rdata});
        check("err", {31'd0, port_d ? bus.d_err : bus.i_err}, {31'd0, exp_err});
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        logic got;
        logic exp_d;
        n_checks = 0; n_fail = 0;
        stall_n = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h08] = 16'hBEEF;  // byte 0x0010
        mem[8'h18] = 16'hAAAA;  // byte 0x0030
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch read, done on first BUSY cycle.
        run_op(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0);
        @(negedge clk);
        check("i_done_pulse", {31'd0, bus.i_done}, 0);
        check("i_rdata_hold", {16'd0, bus.i_rdata}, 32'h0000BEEF);
        @(posedge clk); #1;

        // Data write with 4 stalls, then read back.
        run_op(1'b1, 1'b1, 16'h0020, 16'h1234, 4, 16'h0000, 1'b0);
        check("mem_write", {16'd0, mem[8'h10]}, 32'h00001234);
        run_op(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 16'h1234, 1'b0);

        // Misaligned read and write: err reported, memory untouched.
        run_op(1'b1, 1'b0, 16'h0021, 16'h0000, 1, 16'h0000, 1'b1);
        run_op(1'b1, 1'b1, 16'h0021, 16'hDEAD, 0, 16'h0000, 1'b1);
        check("err_no_write", {16'd0, mem[8'h10]}, 32'h00001234);
        check("i_err_hold",   {31'd0, bus.i_err}, 0);

        // Fetch grant last, then continuous contention.
        run_op(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0);
        stall_n = 0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        for (int g = 0; g < 4; g++) begin
            cyc = 0; got = 1'b0;
            while (!got && cyc < 10) begin
                @(negedge clk);
                if (bus.i_ack || bus.d_ack) got = 1'b1;
                else begin
                    cyc++;
                    @(posedge clk); #1;
                end
            end
            if (!got) begin
                check("grant_timeout", 0, 1);
            end else begin
`ifdef MEM_ARB_FAIRNESS_EN
                exp_d = (g % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                check("grant_port",  {31'd0, bus.d_ack}, {31'd0, exp_d});
                check("grant_onehot", {31'd0, bus.i_ack ^ bus.d_ack}, 1);
                if (g > 0) check("grant_gap", cyc, 2);
                @(posedge clk); #1;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset two cycles into a stalled write.
        stall_n = 6;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0030; bus.d_wdata = 16'h5555;
        @(negedge clk);
        check("rstw_ack", {31'd0, bus.d_ack}, 1);
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        check("rstw_wr1", {31'd0, bus.mem_wr}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstw_wr2", {31'd0, bus.mem_wr}, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rstw");
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rstw_no_done", {31'd0, bus.d_done}, 0);
            check("rstw_no_wr",   {31'd0, bus.mem_wr}, 0);
        end
        check("rstw_mem", {16'd0, mem[8'h18]}, 32'h0000AAAA);
        @(posedge clk); #1;

        // Operational after reset.
        run_op(1'b0, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
